// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller (FSM: IDLE/FILL/WRITE).
// Optional hit/miss statistics counters are built when macro DCACHE_STATS_EN is defined.
module data_cache_controller #(
  parameter int unsigned LINES       = 4,
  parameter int unsigned FILL_CYCLES = 5
) (
  input  logic         CLk,
  input  logic         reset,
  input  logic [31:0]  cpuAddress,
  input  logic [31:0]  cpuWriteData,
  input  logic         cpuRead,
  input  logic         cpuWrite,
  output logic [31:0]  cpuReadData,
  output logic         cpuReady,
  output logic [31:0]  memAddress,
  output logic [31:0]  memInputData,
  output logic         memWriteMem,
  input  logic [127:0] memData
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hitCount,
  output logic [31:0]  missCount
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;
  localparam int unsigned CNT_W = $clog2(FILL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word_sel;
  logic [127:0]       line;
  logic [31:0]        sel_word;
  logic               hit;
  logic               fill_last;
  logic               unused_addr_bits;

  assign idx              = cpuAddress[4 +: IDX_W];
  assign tag              = cpuAddress[31 -: TAG_W];
  assign word_sel         = cpuAddress[3:2];
  assign unused_addr_bits = ^cpuAddress[1:0];

  assign line      = data_q[idx];
  assign sel_word  = line[{word_sel, 5'b00000} +: 32];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_last = (state_q == FILL) && (cnt_q == CNT_W'(FILL_CYCLES - 1));

  always_ff @(posedge CLk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_last) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Storage needs no reset: valid bits alone gate its use, and reset forces IDLE so no write lands.
  always_ff @(posedge CLk) begin
    if (fill_last) begin
      data_q[idx] <= memData;
      tag_q[idx]  <= tag;
    end else if ((state_q == WRITE) && hit) begin
      data_q[idx][{word_sel, 5'b00000} +: 32] <= cpuWriteData;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cpuReady     = 1'b0;
    cpuReadData  = '0;
    memWriteMem  = 1'b0;
    memAddress   = {cpuAddress[31:4], 4'h0};
    memInputData = cpuWriteData;

    unique case (state_q)
      IDLE: begin
        if (cpuWrite) begin
          state_d = WRITE;
        end else if (cpuRead) begin
          if (hit) begin
            cpuReady    = 1'b1;
            cpuReadData = sel_word;
          end else begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end else begin
          cpuReady = 1'b1;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        memWriteMem = 1'b1;
        memAddress  = {cpuAddress[31:2], 2'b00};
        cpuReady    = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Async reset must silence the handshake outputs immediately, not at the next edge.
    if (reset) begin
      cpuReady    = 1'b0;
      cpuReadData = '0;
      memWriteMem = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        from_fill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        stat_hit, stat_miss;

  // The read completing right after a fill is the tail of a miss, not a hit.
  assign stat_hit  = (state_q == IDLE) && cpuRead && !cpuWrite && hit && !from_fill_q;
  assign stat_miss = (state_q == IDLE) && cpuRead && !cpuWrite && !hit;

  always_ff @(posedge CLk or posedge reset) begin
    if (reset) begin
      from_fill_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      from_fill_q <= fill_last;
      if (stat_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (stat_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed testbench for data_cache_controller with a byte-addressed memory model (byte i = i).
module tb_data_cache_controller;

  logic         CLk = 1'b0;
  logic         reset;
  logic [31:0]  cpuAddress;
  logic [31:0]  cpuWriteData;
  logic         cpuRead;
  logic         cpuWrite;
  logic [31:0]  cpuReadData;
  logic         cpuReady;
  logic [31:0]  memAddress;
  logic [31:0]  memInputData;
  logic         memWriteMem;
  logic [127:0] memData;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hitCount;
  logic [31:0]  missCount;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] mem [256];

  always #5 CLk = ~CLk;

  data_cache_controller #(
    .LINES(4),
    .FILL_CYCLES(5)
  ) dut (
    .CLk          (CLk),
    .reset        (reset),
    .cpuAddress   (cpuAddress),
    .cpuWriteData (cpuWriteData),
    .cpuRead      (cpuRead),
    .cpuWrite     (cpuWrite),
    .cpuReadData  (cpuReadData),
    .cpuReady     (cpuReady),
    .memAddress   (memAddress),
    .memInputData (memInputData),
    .memWriteMem  (memWriteMem),
    .memData      (memData)
`ifdef DCACHE_STATS_EN
    ,
    .hitCount     (hitCount),
    .missCount    (missCount)
`endif
  );

  always_comb begin
    memData = '0;
    for (int k = 0; k < 16; k++) begin
      memData[8*k +: 8] = mem[{memAddress[7:4], 4'(k)}];
    end
  end

  always @(negedge CLk) begin
    if (memWriteMem) begin
      for (int k = 0; k < 4; k++) begin
        mem[{memAddress[7:2], 2'(k)}] <= memInputData[8*k +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at 1ns after a rising edge; counts edges until cpuReady.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_edges);
    int edges;
    cpuAddress = addr;
    cpuRead    = 1'b1;
    cpuWrite   = 1'b0;
    #1;
    edges = 0;
    while (!cpuReady && edges < 30) begin
      @(posedge CLk);
      #1;
      edges++;
    end
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check({tag, "_data"}, cpuReadData, exp);
    check({tag, "_memwr"}, {31'd0, memWriteMem}, 32'd0);
    @(posedge CLk);
    #1;
    cpuRead = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic with_read);
    cpuAddress   = addr;
    cpuWriteData = data;
    cpuWrite     = 1'b1;
    cpuRead      = with_read;
    #1;
    check({tag, "_stall"}, {31'd0, cpuReady}, 32'd0);
    @(posedge CLk);
    #1;
    check({tag, "_strobe"}, {31'd0, memWriteMem}, 32'd1);
    check({tag, "_addr"}, memAddress, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, memInputData, data);
    check({tag, "_ready"}, {31'd0, cpuReady}, 32'd1);
    @(posedge CLk);
    #1;
    cpuWrite = 1'b0;
    cpuRead  = 1'b0;
    #1;
    check({tag, "_strobe_off"}, {31'd0, memWriteMem}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i);
    end
    reset        = 1'b1;
    cpuAddress   = 32'h0000_001C;
    cpuWriteData = '0;
    cpuRead      = 1'b0;
    cpuWrite     = 1'b0;
    repeat (2) @(posedge CLk);
    #1;
    check("rst_ready", {31'd0, cpuReady}, 32'd0);
    check("rst_rdata", cpuReadData, 32'd0);
    check("rst_memwr", {31'd0, memWriteMem}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_ready", {31'd0, cpuReady}, 32'd1);
    check("idle_memaddr", memAddress, 32'h0000_0010);
`ifdef DCACHE_STATS_EN
    check("stats_rst_hit", hitCount, 32'd0);
    check("stats_rst_miss", missCount, 32'd0);
`endif

    do_read("rd14_miss", 32'h14, 32'h1716_1514, 6);
    do_read("rd18_hit", 32'h18, 32'h1B1A_1918, 0);
    do_write("wr14", 32'h14, 32'hDEAD_BEEF, 1'b0);
    do_read("rd14_after_wr", 32'h14, 32'hDEAD_BEEF, 0);
`ifdef DCACHE_STATS_EN
    check("stats_hit", hitCount, 32'd2);
    check("stats_miss", missCount, 32'd1);
`endif

    do_write("wr30_miss", 32'h30, 32'hCAFE_F00D, 1'b1);
    do_read("rd30_noalloc", 32'h30, 32'hCAFE_F00D, 6);

    do_read("rd00_a", 32'h00, 32'h0302_0100, 6);
    do_read("rd40_conflict", 32'h40, 32'h4342_4140, 6);
    do_read("rd00_b", 32'h00, 32'h0302_0100, 6);

    cpuAddress = 32'h20;
    cpuRead    = 1'b1;
    @(posedge CLk);
    #1;
    repeat (2) begin
      @(posedge CLk);
      #1;
    end
    check("fill_memaddr", memAddress, 32'h0000_0020);
    check("fill_stall", {31'd0, cpuReady}, 32'd0);
    @(posedge CLk);
    #1;
    reset   = 1'b1;
    cpuRead = 1'b0;
    #1;
    check("fillrst_ready", {31'd0, cpuReady}, 32'd0);
    repeat (2) @(posedge CLk);
    #1;
    reset = 1'b0;
    do_read("rd20_refill", 32'h20, 32'h2322_2120, 6);

    cpuAddress   = 32'h50;
    cpuWriteData = 32'h1234_5678;
    cpuWrite     = 1'b1;
    @(posedge CLk);
    #1;
    check("wrrst_strobe_on", {31'd0, memWriteMem}, 32'd1);
    reset = 1'b1;
    #1;
    check("wrrst_strobe_off", {31'd0, memWriteMem}, 32'd0);
    cpuWrite = 1'b0;
    @(posedge CLk);
    #1;
    reset = 1'b0;
    do_read("rd18_empty", 32'h18, 32'h1B1A_1918, 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

Interface
REQ-001 The block SHALL have parameter LINES, default 4, giving the number of direct-mapped 16-byte lines (power of 2, at least 2).
REQ-002 The block SHALL have parameter FILL_CYCLES, default 5, giving the number of rising edges memData is waited for during a fill.
REQ-003 CLk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 cpuAddress  input  32  byte address from the CPU.
REQ-006 cpuWriteData  input  32  store data.
REQ-007 cpuRead  input  1  load request, level-held until cpuReady.
REQ-008 cpuWrite  input  1  store request, level-held until cpuReady.
REQ-009 cpuReadData  output  32  load data, valid when cpuReady=1 and cpuRead=1.
REQ-010 cpuReady  output  1  request completes this cycle; 0 means stall.
REQ-011 memAddress  output  32  byte address to the data memory.
REQ-012 memInputData  output  32  store data to the data memory.
REQ-013 memWriteMem  output  1  memory write strobe; memory samples it on the falling edge.
REQ-014 memData  input  128  16-byte line from memory, byte k at bits [8k+7:8k].

Function
REQ-015 The address split SHALL be: offset=cpuAddress[3:0], word=cpuAddress[3:2], index=cpuAddress[4+log2(LINES)-1:4], tag=remaining upper bits; bits [1:0] ignored.
REQ-016 The FSM SHALL have exactly the states IDLE, FILL and WRITE.
REQ-017 IDLE, cpuWrite=1 (including when cpuRead=1 too; write wins): go to WRITE, cpuReady=0.
REQ-018 IDLE, cpuRead=1, cpuWrite=0, hit (valid and tag match): cpuReady=1 combinationally and cpuReadData=selected word in the same cycle; stay in IDLE.
REQ-019 IDLE, cpuRead=1, cpuWrite=0, miss: go to FILL with cpuReady=0.
REQ-020 IDLE, no request: cpuReady=1, memWriteMem=0.
REQ-021 FILL SHALL hold memAddress={cpuAddress[31:4],4'h0} stable and count rising edges from 1; on edge FILL_CYCLES it SHALL write memData into the indexed line, set tag and valid, and return to IDLE, where the held read then hits.
REQ-022 WRITE SHALL last exactly one cycle with memWriteMem=1, memAddress={cpuAddress[31:2],2'b00}, memInputData=cpuWriteData and cpuReady=1, then return to IDLE.
REQ-023 On a write hit, the block SHALL update the addressed word in the line on the WRITE-cycle edge (write-through). On a write miss, the cache SHALL remain unchanged (no write-allocate).
REQ-024 memWriteMem SHALL be 0 in IDLE and FILL. In IDLE, memAddress SHALL equal the line-aligned cpuAddress.
REQ-025 A conflict miss SHALL overwrite the indexed line with no writeback, because the cache is always clean.
REQ-026 cpuAddress, cpuRead and cpuWrite changing during FILL or WRITE is a protocol violation, and the block's behaviour is then unspecified.

Reset
REQ-027 While reset=1, the block SHALL clear all valid bits, set state=IDLE and the fill counter=0, and drive memWriteMem=0, cpuReady=0 and cpuReadData=0.
REQ-028 Reset during FILL SHALL abandon the fill, leaving the target line invalid. Reset during WRITE SHALL drop memWriteMem immediately.
REQ-029 After reset deasserts, the first rising edge SHALL see IDLE with an empty cache.

Configuration
REQ-030 When macro DCACHE_STATS_EN is defined, the block SHALL have 32-bit outputs hitCount and missCount, which reset to 0, add 1 per read hit cycle that completes and per FILL entry respectively, and wrap at 2^32.
REQ-031 When DCACHE_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Memory byte i=i[7:0]; read 0x14 after reset -> FILL for 5 edges, then cpuReady=1 with cpuReadData=0x17161514.
REQ-033 Read 0x18 right after REQ-032 -> hit in the request cycle, cpuReadData=0x1B1A1918, no FILL.
REQ-034 Write 0xDEADBEEF to 0x14 -> one cycle memWriteMem=1, memAddress=0x14, memInputData=0xDEADBEEF; a following read of 0x14 hits and returns 0xDEADBEEF.
REQ-035 LINES=4: read 0x00, then 0x40 (same index), then 0x00 -> three fills; the last read returns 0x03020100.
REQ-036 Assert reset on the 3rd FILL edge of a read of 0x20; after release, a read of 0x20 -> full 5-edge fill again, returning 0x23222120.
REQ-037 With DCACHE_STATS_EN: run REQ-032 through REQ-034 -> hitCount=2, missCount=1; without the macro, the port list lacks both counters.
